// File: rtl/int_flag_seq_if.sv
// Control-unit side of the RAT interrupt sequencer: request pulses in, sequencing strobes out.
interface int_flag_seq_if;
  logic       I_SET;
  logic       I_CLR;
  logic       RETIE;
  logic       INSTR_BOUNDARY;
  logic       INT_TAKE;
  logic       SP_PUSH;
  logic       PC_VEC_LD;
  logic [9:0] PC_VEC;
  logic       FLG_SHAD_LD;
  logic       FLG_LD_SEL;
  logic       FLG_RESTORE_LD;
  logic       I_FLAG;
  logic       PENDING;
  logic       IN_ISR;

  modport master (
    output I_SET, I_CLR, RETIE, INSTR_BOUNDARY,
    input  INT_TAKE, SP_PUSH, PC_VEC_LD, PC_VEC, FLG_SHAD_LD, FLG_LD_SEL,
           FLG_RESTORE_LD, I_FLAG, PENDING, IN_ISR
  );

  modport slave (
    input  I_SET, I_CLR, RETIE, INSTR_BOUNDARY,
    output INT_TAKE, SP_PUSH, PC_VEC_LD, PC_VEC, FLG_SHAD_LD, FLG_LD_SEL,
           FLG_RESTORE_LD, I_FLAG, PENDING, IN_ISR
  );
endinterface

// File: rtl/int_flag_seq.sv
// RAT MCU interrupt sequencer: INTR sync/edge detect, I flag, pending latch, entry/return FSM.
// Optional macro INT_DEBOUNCE_EN: qualify INTR edges with a DB_CYCLES-long high debounce.
module int_flag_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [9:0]  VECTOR      = 10'h3FF,
  parameter int unsigned DB_CYCLES   = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         INTR,
  int_flag_seq_if.slave bus
);

  if (SYNC_STAGES < 2 || DB_CYCLES < 1) begin : g_param_check
    $error("int_flag_seq: SYNC_STAGES must be >= 2 and DB_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    VEC,
    ISR,
    RESTORE
  } state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic                   rise;
  logic                   i_flag;
  logic                   pending;

  always_ff @(posedge CLK) begin
    if (RST) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], INTR};
  end

  assign sync_out = sync[SYNC_STAGES-1];

`ifdef INT_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] DB_FULL = CW'(DB_CYCLES);
  logic [CW-1:0] db_cnt;

  // Counter saturates at DB_CYCLES so the qualifying sample fires once per high period.
  always_ff @(posedge CLK) begin
    if (RST || !sync_out)      db_cnt <= '0;
    else if (db_cnt != DB_FULL) db_cnt <= db_cnt + 1'b1;
  end

  assign rise = sync_out && (db_cnt == DB_LAST);
`else
  logic sync_prev;

  always_ff @(posedge CLK) begin
    if (RST) sync_prev <= 1'b0;
    else     sync_prev <= sync_out;
  end

  assign rise = sync_out & ~sync_prev;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (bus.RETIE)                                        state_n = RESTORE;
        else if (bus.INSTR_BOUNDARY && pending && i_flag)     state_n = ENTRY;
      end
      ENTRY:   state_n = VEC;
      VEC:     state_n = ISR;
      ISR:     if (bus.RETIE) state_n = RESTORE;
      RESTORE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST)                    i_flag <= 1'b0;
    else if (bus.I_CLR)         i_flag <= 1'b0;
    else if (bus.I_SET)         i_flag <= 1'b1;
    else if (state == ENTRY)    i_flag <= 1'b0;
    else if (state == RESTORE)  i_flag <= 1'b1;
  end

  // Clears take precedence over a coincident qualified edge.
  always_ff @(posedge CLK) begin
    if (RST || bus.I_CLR || state == ENTRY) pending <= 1'b0;
    else if (rise && i_flag)                pending <= 1'b1;
  end

  always_comb begin
    bus.INT_TAKE       = 1'b0;
    bus.SP_PUSH        = 1'b0;
    bus.FLG_SHAD_LD    = 1'b0;
    bus.PC_VEC_LD      = 1'b0;
    bus.FLG_LD_SEL     = 1'b0;
    bus.FLG_RESTORE_LD = 1'b0;
    bus.IN_ISR         = 1'b0;
    unique case (state)
      ENTRY: begin
        bus.INT_TAKE    = 1'b1;
        bus.SP_PUSH     = 1'b1;
        bus.FLG_SHAD_LD = 1'b1;
      end
      VEC: begin
        bus.PC_VEC_LD = 1'b1;
        bus.IN_ISR    = 1'b1;
      end
      ISR: bus.IN_ISR = 1'b1;
      RESTORE: begin
        bus.FLG_LD_SEL     = 1'b1;
        bus.FLG_RESTORE_LD = 1'b1;
        bus.IN_ISR         = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.PC_VEC  = VECTOR;
  assign bus.I_FLAG  = i_flag;
  assign bus.PENDING = pending;

endmodule

// File: tb/tb_int_flag_seq.sv
// Directed bench for int_flag_seq: entry/return sequencing, I/PENDING priorities, reset abort.
module tb_int_flag_seq;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DB   = 4;
`ifdef INT_DEBOUNCE_EN
  localparam int unsigned LAT = SYNC + DB;
`else
  localparam int unsigned LAT = SYNC + 1;
`endif

  logic CLK = 1'b0;
  logic RST;
  logic INTR;
  int   total = 0;
  int   bad   = 0;

  int_flag_seq_if bus ();

  int_flag_seq #(
    .SYNC_STAGES (SYNC),
    .VECTOR      (10'h3FF),
    .DB_CYCLES   (DB)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .INTR (INTR),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_sei();
    bus.I_SET = 1'b1; step(); bus.I_SET = 1'b0;
  endtask

  task automatic pulse_cli();
    bus.I_CLR = 1'b1; step(); bus.I_CLR = 1'b0;
  endtask

  task automatic boundary();
    bus.INSTR_BOUNDARY = 1'b1; step(); bus.INSTR_BOUNDARY = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_take"},   {15'd0, bus.INT_TAKE},       16'd0);
    check({tag, "_vecld"},  {15'd0, bus.PC_VEC_LD},      16'd0);
    check({tag, "_inisr"},  {15'd0, bus.IN_ISR},         16'd0);
    check({tag, "_ldsel"},  {15'd0, bus.FLG_LD_SEL},     16'd0);
    check({tag, "_rstld"},  {15'd0, bus.FLG_RESTORE_LD}, 16'd0);
    check({tag, "_shad"},   {15'd0, bus.FLG_SHAD_LD},    16'd0);
    check({tag, "_iflag"},  {15'd0, bus.I_FLAG},         16'd0);
    check({tag, "_pend"},   {15'd0, bus.PENDING},        16'd0);
  endtask

  initial begin
    RST = 1'b1; INTR = 1'b0;
    bus.I_SET = 1'b0; bus.I_CLR = 1'b0; bus.RETIE = 1'b0; bus.INSTR_BOUNDARY = 1'b0;
    step(); step();
    check_quiet("reset");
    RST = 1'b0;
    step();

    // Test 1: edge latched after LAT clocks, then entry and vector on consecutive cycles
    pulse_sei();
    check("sei_iflag", {15'd0, bus.I_FLAG}, 16'd1);
    INTR = 1'b1;
    for (int i = 0; i < int'(LAT) - 1; i++) step();
    check("pend_early", {15'd0, bus.PENDING}, 16'd0);
    step();
    check("pend_set", {15'd0, bus.PENDING}, 16'd1);
    step(); step();
    INTR = 1'b0;
    boundary();
    check("entry_take",  {15'd0, bus.INT_TAKE},    16'd1);
    check("entry_push",  {15'd0, bus.SP_PUSH},     16'd1);
    check("entry_shad",  {15'd0, bus.FLG_SHAD_LD}, 16'd1);
    check("entry_vecld", {15'd0, bus.PC_VEC_LD},   16'd0);
    step();
    check("vec_ld",    {15'd0, bus.PC_VEC_LD}, 16'd1);
    check("vec_addr",  {6'd0, bus.PC_VEC},     16'h03FF);
    check("vec_take",  {15'd0, bus.INT_TAKE},  16'd0);
    check("vec_iflag", {15'd0, bus.I_FLAG},    16'd0);
    check("vec_pend",  {15'd0, bus.PENDING},   16'd0);
    check("vec_inisr", {15'd0, bus.IN_ISR},    16'd1);
    step();
    check("isr_inisr", {15'd0, bus.IN_ISR},    16'd1);
    check("isr_vecld", {15'd0, bus.PC_VEC_LD}, 16'd0);

    // Test 3: RETIE from ISR gives a single restore cycle then re-enables
    bus.RETIE = 1'b1; step(); bus.RETIE = 1'b0;
    check("rest_sel",   {15'd0, bus.FLG_LD_SEL},     16'd1);
    check("rest_ld",    {15'd0, bus.FLG_RESTORE_LD}, 16'd1);
    check("rest_inisr", {15'd0, bus.IN_ISR},         16'd1);
    step();
    check("post_sel",   {15'd0, bus.FLG_LD_SEL},     16'd0);
    check("post_ld",    {15'd0, bus.FLG_RESTORE_LD}, 16'd0);
    check("post_iflag", {15'd0, bus.I_FLAG},         16'd1);
    check("post_inisr", {15'd0, bus.IN_ISR},         16'd0);

    // Test 2: edges with I disabled are discarded
    pulse_cli();
    check("cli_iflag", {15'd0, bus.I_FLAG}, 16'd0);
    INTR = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("dis_pend", {15'd0, bus.PENDING}, 16'd0);
    end
    INTR = 1'b0;
    for (int i = 0; i < 3; i++) begin
      boundary();
      check("dis_take", {15'd0, bus.INT_TAKE}, 16'd0);
      step();
    end

    // Test 4: CLI wins over SEI; clear wins over coincident edge
    bus.I_SET = 1'b1; bus.I_CLR = 1'b1; step(); bus.I_SET = 1'b0; bus.I_CLR = 1'b0;
    check("setclr_iflag", {15'd0, bus.I_FLAG}, 16'd0);
    pulse_sei();
    INTR = 1'b1;
    for (int i = 0; i < int'(LAT) - 1; i++) step();
    pulse_cli();
    check("riseclr_pend", {15'd0, bus.PENDING}, 16'd0);
    INTR = 1'b0;
    step(); step(); step();
    check("riseclr_pend2", {15'd0, bus.PENDING}, 16'd0);

    // RETIE in IDLE still restores and sets I
    bus.RETIE = 1'b1; step(); bus.RETIE = 1'b0;
    check("idle_ret_ld", {15'd0, bus.FLG_RESTORE_LD}, 16'd1);
    step();
    check("idle_ret_iflag", {15'd0, bus.I_FLAG}, 16'd1);

    // Test 5: reset during VEC aborts cleanly; later interrupt serviced normally
    INTR = 1'b1;
    for (int i = 0; i < int'(LAT); i++) step();
    INTR = 1'b0;
    check("t5_pend", {15'd0, bus.PENDING}, 16'd1);
    boundary();
    step();
    check("t5_vecld", {15'd0, bus.PC_VEC_LD}, 16'd1);
    RST = 1'b1; step(); RST = 1'b0;
    check_quiet("midrst");
    step(); step(); step();
    pulse_sei();
    INTR = 1'b1;
    for (int i = 0; i < int'(LAT); i++) step();
    INTR = 1'b0;
    check("t5b_pend", {15'd0, bus.PENDING}, 16'd1);
    boundary();
    check("t5b_take", {15'd0, bus.INT_TAKE}, 16'd1);
    step();
    check("t5b_vecld", {15'd0, bus.PC_VEC_LD}, 16'd1);
    step();
    bus.RETIE = 1'b1; step(); bus.RETIE = 1'b0;
    step();
    check("t5b_iflag", {15'd0, bus.I_FLAG}, 16'd1);
    step(); step(); step();

`ifdef INT_DEBOUNCE_EN
    // Test 6: short highs rejected; long high fires exactly once
    INTR = 1'b1;
    step(); step(); step();
    INTR = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("db_short_pend", {15'd0, bus.PENDING}, 16'd0);
    end
    INTR = 1'b1;
    for (int i = 0; i < int'(LAT); i++) step();
    check("db_long_pend", {15'd0, bus.PENDING}, 16'd1);
    pulse_cli();
    pulse_sei();
    for (int i = 0; i < 4; i++) begin
      step();
      check("db_once_pend", {15'd0, bus.PENDING}, 16'd0);
    end
    INTR = 1'b0;
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach end, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/int_flag_seq.md
Name: int_flag_seq

Overview:
Interrupt sequencer for the RAT MCU. It sits directly upstream of the C/Z flag register and drives its shadow-save and restore controls. It synchronises and edge-detects the external interrupt, holds the interrupt-enable (I) flag and a pending latch, and runs the entry/return sequence at instruction boundaries. The control unit consumes INT_TAKE, SP_PUSH and PC_VEC_LD. It ORs FLG_RESTORE_LD into its own C/Z load strobes.

Parameters:
SYNC_STAGES, 2, number of flops in the INTR synchroniser (minimum 2)
VECTOR, 10'h3FF, ISR entry address driven on PC_VEC
DB_CYCLES, 4, debounce length in clocks (used only with INT_DEBOUNCE_EN)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
INTR  in  1  raw external interrupt request, asynchronous
I_SET  in  1  SEI executing (1-cycle pulse from control unit)
I_CLR  in  1  CLI executing (1-cycle pulse)
RETIE  in  1  RETIE executing (1-cycle pulse)
INSTR_BOUNDARY  in  1  last cycle of an instruction's execute phase
INT_TAKE  out  1  interrupt entry cycle; control unit diverts from next fetch
SP_PUSH  out  1  push current PC onto the stack
PC_VEC_LD  out  1  load PC from PC_VEC
PC_VEC  out  10  constant VECTOR
FLG_SHAD_LD  out  1  copy C/Z into the shadow registers
FLG_LD_SEL  out  1  1 = flag inputs taken from the shadow registers
FLG_RESTORE_LD  out  1  load C and Z from the shadow registers
I_FLAG  out  1  interrupt enable
PENDING  out  1  interrupt latched, awaiting service
IN_ISR  out  1  ISR in progress

Behaviour:
- Reset (RST=1 at a rising edge): state IDLE, synchroniser and edge flop cleared, I_FLAG=0, PENDING=0, all strobes 0. Reset mid-sequence aborts it with no partial strobes the following cycle.
- Synchroniser: SYNC_STAGES flops. rise = sync_out & ~sync_prev. Latency from INTR high to rise is SYNC_STAGES+1 clocks.
- PENDING: set on rise when I_FLAG=1. Edges while I_FLAG=0 are discarded. Cleared on the ENTRY cycle, on I_CLR, or on reset. If rise and a clear occur in the same cycle, the clear wins.
- I_FLAG: I_CLR has priority over I_SET, and I_SET over hold. Cleared at the end of ENTRY. Set at the end of RESTORE.
- FSM states, with outputs decoded from the state register only:
  IDLE: all strobes 0. If INSTR_BOUNDARY & PENDING & I_FLAG, go to ENTRY. Otherwise stay.
  ENTRY (1 cycle): INT_TAKE=1, SP_PUSH=1, FLG_SHAD_LD=1. Go to VEC.
  VEC (1 cycle): PC_VEC_LD=1, IN_ISR=1. Go to ISR.
  ISR: IN_ISR=1. On RETIE go to RESTORE. New interrupts are latched only if software executes SEI inside the ISR. No nesting is taken: the IDLE-only take rule applies.
  RESTORE (1 cycle): FLG_LD_SEL=1, FLG_RESTORE_LD=1, IN_ISR=1. Go to IDLE.
- RETIE while in IDLE: one-cycle RESTORE still occurs and I_FLAG is set, as required by ISA semantics. RETIE in ENTRY or VEC is ignored.
- FLG_LD_SEL is 0 in every state except RESTORE.
- Latency: boundary pulse to INT_TAKE is 1 clock. INT_TAKE to PC_VEC_LD is 1 clock.

Optional Feature:
INT_DEBOUNCE_EN:
- Defined: rise is qualified only after the synchronised INTR has been high for DB_CYCLES consecutive clocks. Uses a $clog2(DB_CYCLES+1)-bit counter, which resets to 0 on any low sample. Exactly one rise fires per high period.
- Undefined: plain edge detect; the counter logic is absent.

Test Plan:
1. RST, then SEI; INTR 0->1 held 5 clocks; INSTR_BOUNDARY pulse 2 clocks after PENDING=1 -> INT_TAKE/SP_PUSH/FLG_SHAD_LD high 1 clock after the boundary, PC_VEC_LD=1 with PC_VEC=10'h3FF the next clock, I_FLAG=0, PENDING=0.
2. I_FLAG=0, INTR pulses high -> PENDING stays 0; no INT_TAKE across 3 boundary pulses.
3. In ISR, pulse RETIE -> next clock FLG_LD_SEL=1 and FLG_RESTORE_LD=1 for exactly 1 clock, then I_FLAG=1, IN_ISR=0, state IDLE.
4. I_SET and I_CLR in the same cycle -> I_FLAG=0. Rise and I_CLR in the same cycle -> PENDING=0.
5. Assert RST during VEC -> next clock all outputs 0 and I_FLAG=0. A later interrupt after SEI is serviced normally.
6. With INT_DEBOUNCE_EN and DB_CYCLES=4: INTR high 3 clocks -> PENDING stays 0. INTR high 6 clocks -> PENDING=1 exactly once.
